// File: rtl/alu_sweep_driver_if.sv
// Record stream between the ALU sweep driver and its consumer.
//   rec_valid : record available (driver -> consumer)
//   rec_ready : consumer accepts the record (consumer -> driver)
//   rec_data  : {alu_op, alu_a, alu_b, captured result}
interface alu_sweep_driver_if;
  logic        rec_valid;
  logic        rec_ready;
  logic [15:0] rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/alu_sweep_driver.sv
// Exhaustive ALU stimulus sweep: walks every {opcode, A, B} combination
// allowed by OP_MASK, waits SETTLE_CYCLES edges, captures alu_result and
// emits one record per combination over a valid/ready stream, keeping a
// running 16-bit checksum of captured results.
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             single-cycle pulse starting a sweep (ignored while busy)
//   alu_a/alu_b/alu_op operands and opcode driven to the ALU
//   alu_result        ALU result read back
//   rec               record stream (master side)
//   busy, done        sweep in progress / sweep complete (level)
//   checksum          sum of captured results mod 2^16
//   rec_count         records accepted in the current or last sweep
module alu_sweep_driver #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] OP_MASK       = 16'h7FFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [1:0]                 alu_a,
  output logic [1:0]                 alu_b,
  output logic [3:0]                 alu_op,
  input  logic [7:0]                 alu_result,
  alu_sweep_driver_if.master         rec,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                checksum,
  output logic [8:0]                 rec_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_DRIVE,
    S_SEND,
    S_FIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  idx;
  logic [3:0]  settle;
  logic        idx_en;
  logic        idx_last;
  logic        settle_done;
  logic        accept;

  always_comb begin
    idx_en      = OP_MASK[idx[7:4]];
    idx_last    = (idx == 8'hFF);
    // settle counts edges already seen in DRIVE; the capture edge is the
    // SETTLE_CYCLES-th edge after the SEEK edge that loaded alu_*.
    settle_done = (settle == 4'(SETTLE_CYCLES - 1));
    accept      = rec.rec_valid && rec.rec_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_SEEK;
      S_SEEK: begin
        if (idx_en)        state_nxt = S_DRIVE;
        else if (idx_last) state_nxt = S_FIN;
      end
      S_DRIVE: if (settle_done) state_nxt = S_SEND;
      S_SEND: begin
        if (accept) state_nxt = idx_last ? S_FIN : S_SEEK;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx           <= '0;
      settle        <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= '0;
      rec.rec_data  <= '0;
      rec.rec_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      checksum      <= '0;
      rec_count     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            checksum  <= '0;
            rec_count <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            idx       <= '0;
          end
        end
        S_SEEK: begin
          if (idx_en) begin
            alu_op <= idx[7:4];
            alu_a  <= idx[3:2];
            alu_b  <= idx[1:0];
            settle <= '0;
          end else if (!idx_last) begin
            idx <= idx + 8'd1;
          end
        end
        S_DRIVE: begin
          settle <= settle + 4'd1;
          if (settle_done) begin
            rec.rec_data  <= {idx, alu_result};
            checksum      <= checksum + {8'h00, alu_result};
            rec.rec_valid <= 1'b1;
          end
        end
        S_SEND: begin
          if (accept) begin
            rec.rec_valid <= 1'b0;
            rec_count     <= rec_count + 9'd1;
            if (!idx_last) idx <= idx + 8'd1;
          end
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sweep_driver.sv
module tb_alu_sweep_driver;

  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- main DUT: default mask, stub ALU ----------------
  alu_sweep_driver_if rec_m ();
  logic        start_m;
  logic [1:0]  a_m, b_m;
  logic [3:0]  op_m;
  logic [7:0]  res_m;
  logic        busy_m, done_m;
  logic [15:0] cks_m;
  logic [8:0]  cnt_m;
  logic        stub_const;

  assign res_m = stub_const ? 8'h01 : {op_m, a_m, b_m};

  alu_sweep_driver #(.SETTLE_CYCLES(SETTLE), .OP_MASK(16'h7FFF)) u_main (
    .clk(clk), .rst(rst), .start(start_m),
    .alu_a(a_m), .alu_b(b_m), .alu_op(op_m), .alu_result(res_m),
    .rec(rec_m), .busy(busy_m), .done(done_m),
    .checksum(cks_m), .rec_count(cnt_m)
  );

  // ---------------- AND-only DUT with AND ALU model ----------------
  alu_sweep_driver_if rec_a ();
  logic        start_a;
  logic [1:0]  a_a, b_a;
  logic [3:0]  op_a;
  logic [7:0]  res_a;
  logic        busy_a, done_a;
  logic [15:0] cks_a;
  logic [8:0]  cnt_a;

  assign res_a = {6'b0, a_a & b_a};

  alu_sweep_driver #(.SETTLE_CYCLES(SETTLE), .OP_MASK(16'h0001)) u_and (
    .clk(clk), .rst(rst), .start(start_a),
    .alu_a(a_a), .alu_b(b_a), .alu_op(op_a), .alu_result(res_a),
    .rec(rec_a), .busy(busy_a), .done(done_a),
    .checksum(cks_a), .rec_count(cnt_a)
  );

  // ---------------- empty-mask DUT ----------------
  alu_sweep_driver_if rec_z ();
  logic        start_z;
  logic [1:0]  a_z, b_z;
  logic [3:0]  op_z;
  logic        busy_z, done_z;
  logic [15:0] cks_z;
  logic [8:0]  cnt_z;

  alu_sweep_driver #(.SETTLE_CYCLES(SETTLE), .OP_MASK(16'h0000)) u_zero (
    .clk(clk), .rst(rst), .start(start_z),
    .alu_a(a_z), .alu_b(b_z), .alu_op(op_z), .alu_result(8'hA5),
    .rec(rec_z), .busy(busy_z), .done(done_z),
    .checksum(cks_z), .rec_count(cnt_z)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] q_m[$];
  logic [15:0] q_a[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rec_m.rec_valid && rec_m.rec_ready) begin
      if (q_m.size() == 0) check("rec_m_unexpected", 32'd1, 32'd0);
      else                 check("rec_m_data", {16'h0, rec_m.rec_data}, {16'h0, q_m.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && rec_a.rec_valid && rec_a.rec_ready) begin
      if (rec_a.rec_data[15:8] == 8'h0E) check("and_a3_b2", {16'h0, rec_a.rec_data}, 32'h0E02);
      if (q_a.size() == 0) check("rec_a_unexpected", 32'd1, 32'd0);
      else                 check("rec_a_data", {16'h0, rec_a.rec_data}, {16'h0, q_a.pop_front()});
    end
  end

  // inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_main(input bit cst);
    for (int i = 0; i < 240; i++) begin
      logic [7:0] k;
      k = 8'(i);
      q_m.push_back({k, cst ? 8'h01 : k});
    end
  endtask

  task automatic check_main_zero(input string tag);
    check({tag, "_alu"},   {24'h0, op_m, a_m, b_m}, 32'h0);
    check({tag, "_data"},  {16'h0, rec_m.rec_data}, 32'h0);
    check({tag, "_valid"}, {31'h0, rec_m.rec_valid}, 32'h0);
    check({tag, "_busy"},  {31'h0, busy_m}, 32'h0);
    check({tag, "_done"},  {31'h0, done_m}, 32'h0);
    check({tag, "_cks"},   {16'h0, cks_m}, 32'h0);
    check({tag, "_cnt"},   {23'h0, cnt_m}, 32'h0);
  endtask

  // One sweep on the main DUT. bp: stall the 3rd record for 20 cycles.
  // thr: check record spacing. rst_at: nonzero -> reset while that record is presented.
  task automatic run_main(input bit bp, input bit thr, input int rst_at,
                          input logic [15:0] exp_cks);
    int t = 0, nrise = 0, last_rise = 0;
    bit prev_rv = 1'b0, prev_busy = 1'b0, held = 1'b0, fin = 1'b0;
    logic [15:0] snap_d;
    logic [7:0]  snap_alu;
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    while (!fin && t < 5000) begin
      if (t > 0) tick();
      t++;
      if (rec_m.rec_valid && !prev_rv) begin
        nrise++;
        if (thr && nrise > 1) check("throughput", t - last_rise, SETTLE + 2);
        last_rise = t;
      end
      if (done_m) begin
        check("busy_falls_with_done", {30'h0, prev_busy, busy_m}, 32'b10);
        fin = 1'b1;
      end
      if (rst_at != 0 && nrise == rst_at) begin
        rst = 1'b1;
        #1;
        check_main_zero("midrst");
        q_m.delete();
        tick();
        rst = 1'b0;
        return;
      end
      if (bp && nrise == 3 && !held) begin
        rec_m.rec_ready = 1'b0;
        snap_d   = rec_m.rec_data;
        snap_alu = {op_m, a_m, b_m};
        repeat (20) begin
          tick();
          t++;
          check("bp_valid", {31'h0, rec_m.rec_valid}, 32'h1);
          check("bp_data",  {16'h0, rec_m.rec_data}, {16'h0, snap_d});
          check("bp_alu",   {24'h0, op_m, a_m, b_m}, {24'h0, snap_alu});
        end
        rec_m.rec_ready = 1'b1;
        held = 1'b1;
      end
      prev_rv   = rec_m.rec_valid;
      prev_busy = busy_m;
    end
    check("main_done_seen", {31'h0, fin}, 32'h1);
    check("main_checksum", {16'h0, cks_m}, {16'h0, exp_cks});
    check("main_rec_count", {23'h0, cnt_m}, 32'd240);
    check("main_queue_left", q_m.size(), 32'd0);
  endtask

  initial begin
    int cnt;
    bit rv_seen;
    logic [15:0] exp_and;

    rst = 1'b1;
    start_m = 1'b0; start_a = 1'b0; start_z = 1'b0;
    stub_const = 1'b0;
    rec_m.rec_ready = 1'b1;
    rec_a.rec_ready = 1'b1;
    rec_z.rec_ready = 1'b1;
    tick(); tick();
    check_main_zero("reset");
    rst = 1'b0;
    tick();

    // loopback stub with backpressure on the 3rd record
    push_main(1'b0);
    run_main(1'b1, 1'b0, 0, 16'h7008);
    check("main_done_level", {31'h0, done_m}, 32'h1);

    // constant stub, throughput
    tick();
    stub_const = 1'b1;
    push_main(1'b1);
    run_main(1'b0, 1'b1, 0, 16'h00F0);

    // reset during the 50th record, then a clean sweep
    tick();
    stub_const = 1'b0;
    push_main(1'b0);
    run_main(1'b0, 1'b0, 50, 16'h0);
    push_main(1'b0);
    run_main(1'b0, 1'b0, 0, 16'h7008);

    // AND-only sweep: results a&b over 4x4 operands
    exp_and = 16'h0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        logic [1:0] aa, bb;
        aa = 2'(a);
        bb = 2'(b);
        q_a.push_back({4'h0, aa, bb, 6'b0, aa & bb});
        exp_and = exp_and + 16'(a & b);
      end
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cnt = 0;
    while (!done_a && cnt < 500) begin
      tick();
      cnt++;
    end
    check("and_done", {31'h0, done_a}, 32'h1);
    check("and_count", {23'h0, cnt_a}, 32'd16);
    check("and_checksum", {16'h0, cks_a}, {16'h0, exp_and});
    check("and_queue_left", q_a.size(), 32'd0);

    // empty mask: pure SEEK walk, extra start pulses ignored
    start_z = 1'b1;
    cnt = 0;
    rv_seen = 1'b0;
    while (cnt < 400) begin
      tick();
      cnt++;
      if (rec_z.rec_valid) rv_seen = 1'b1;
      if (done_z) break;
      start_z = (cnt == 100 || cnt == 257);
    end
    start_z = 1'b0;
    check("zero_done_latency", cnt, 32'd258);
    check("zero_no_records", {31'h0, rv_seen}, 32'h0);
    check("zero_count", {23'h0, cnt_z}, 32'd0);
    check("zero_checksum", {16'h0, cks_z}, 32'h0);
    check("zero_busy", {31'h0, busy_z}, 32'h0);
    repeat (3) tick();
    check("zero_stays_done", {30'h0, done_z, busy_z}, 32'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
